// File: rtl/alu_4bit_pkg.sv
// alu_4bit_pkg: shared width and opcode constants for alu_4bit
package alu_4bit_pkg;
  localparam int W = 4;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;
endpackage

// File: rtl/alu_4bit_addsub.sv
// alu_4bit_addsub: shared adder computing a+b or a+~b+1 with carry and signed overflow
module alu_4bit_addsub
  import alu_4bit_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  logic [W-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
  assign overflow = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU, shifts enabled by ALU_SHIFT_EN
module alu_4bit
  import alu_4bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         overflow,
  output logic         out_valid
);
  logic [W-1:0] as_sum, r;
  logic as_c, as_v, c, v;
  alu_4bit_addsub u_addsub (
    .a(a),
    .b(b),
    .sub(opcode == OP_SUB),
    .sum(as_sum),
    .cout(as_c),
    .overflow(as_v)
  );
  // next result and flags selected by opcode; unsupported opcodes yield zeros
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        r = as_sum;
        c = as_c;
        v = as_v;
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
`ifdef ALU_SHIFT_EN
      OP_SHL: {c, r} = {a, 1'b0};
      OP_SHR: {r, c} = {1'b0, a};
`endif
      default: r = '0;
    endcase
  end
  // capture on accepted input, hold otherwise; reset wins over in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= r;
        cout     <= c;
        zero     <= (r == '0);
        overflow <= v;
      end
    end
  end
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: table and scoreboard driven check of alu_4bit
module tb_alu_4bit;
  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  logic clk = 1'b0, rst, in_valid;
  logic [2:0] opcode;
  logic [3:0] a, b, result;
  logic cout, zero, overflow, out_valid;
  int checks = 0, failures = 0;
  vec_t sb[$];
  vec_t tbl[16];

  alu_4bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .a(a), .b(b),
    .result(result), .cout(cout), .zero(zero), .overflow(overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    vec_t e;
    logic [4:0] s;
    e.op = op; e.a = x; e.b = y; e.c = 1'b0; e.v = 1'b0; e.res = 4'h0;
    case (op)
      3'd0: begin s = x + y; e.res = s[3:0]; e.c = s[4]; e.v = (x[3] == y[3]) && (s[3] != x[3]); end
      3'd1: begin s = {1'b0, x} + {1'b0, ~y} + 5'd1; e.res = s[3:0]; e.c = s[4]; e.v = (x[3] != y[3]) && (s[3] != x[3]); end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~x;
`ifdef ALU_SHIFT_EN
      3'd6: begin e.res = {x[2:0], 1'b0}; e.c = x[3]; end
      3'd7: begin e.res = {1'b0, x[3:1]}; e.c = x[0]; end
`endif
      default: e.res = 4'h0;
    endcase
    e.z = (e.res == 4'h0);
    return e;
  endfunction

  task automatic send(input vec_t t);
    in_valid = 1'b1; opcode = t.op; a = t.a; b = t.b;
    sb.push_back(t);
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input logic [3:0] r, input logic c, input logic z, input logic v);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_result", result, r);
    chk("hold_cout", {3'b0, cout}, {3'b0, c});
    chk("hold_zero", {3'b0, zero}, {3'b0, z});
    chk("hold_overflow", {3'b0, overflow}, {3'b0, v});
    chk("hold_out_valid", {3'b0, out_valid}, 4'h0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious_out_valid", 4'h1, 4'h0);
      else begin
        vec_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("cout", {3'b0, cout}, {3'b0, e.c});
        chk("zero", {3'b0, zero}, {3'b0, e.z});
        chk("overflow", {3'b0, overflow}, {3'b0, e.v});
      end
    end
  end

  initial begin
    tbl[0]  = '{3'd0, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 4'hA, 4'h5, 4'h5, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{3'd2, 4'hA, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3'd3, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 4'hA, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'd0, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{3'd1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3'd5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
`ifdef ALU_SHIFT_EN
    tbl[13] = '{3'd6, 4'h9, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3'd7, 4'h9, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{3'd6, 4'h8, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0};
`else
    tbl[13] = '{3'd6, 4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{3'd7, 4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{3'd6, 4'h8, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
`endif
    rst = 1'b1; in_valid = 1'b0; opcode = 3'd0; a = 4'h0; b = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 4'h0);
    chk("rst_cout", {3'b0, cout}, 4'h0);
    chk("rst_zero", {3'b0, zero}, 4'h0);
    chk("rst_overflow", {3'b0, overflow}, 4'h0);
    chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(tbl[i]);
    for (int i = 0; i < 40; i++)
      send(model(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
    send('{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1});
    repeat (3) idle_chk(4'h8, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; in_valid = 1'b1; opcode = 3'd0; a = 4'hF; b = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rstv_result", result, 4'h0);
    chk("rstv_cout", {3'b0, cout}, 4'h0);
    chk("rstv_zero", {3'b0, zero}, 4'h0);
    chk("rstv_overflow", {3'b0, overflow}, 4'h0);
    chk("rstv_out_valid", {3'b0, out_valid}, 4'h0);
    send('{3'd1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 4'(sb.size()), 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operands/opcode valid this cycle.
REQ-005 opcode  input  3  operation select.
REQ-006 a  input  4  operand A, unsigned or two's complement.
REQ-007 b  input  4  operand B, unsigned or two's complement.
REQ-008 result  output  4  registered operation result.
REQ-009 cout  output  1  registered carry-out, shift-out bit or no-borrow flag.
REQ-010 zero  output  1  registered; 1 when result == 4'b0000.
REQ-011 overflow  output  1  registered signed-overflow flag.
REQ-012 out_valid  output  1  registered; 1 for exactly the cycle after an accepted in_valid.
REQ-013 The block SHALL have no parameters; the data width is fixed at 4.

Function
REQ-014 Opcode map SHALL be 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL by 1, 111 SHR (logical) by 1.
REQ-015 ADD: result = (a+b)[3:0]; cout = bit 4 of the 5-bit sum; overflow = (a[3]==b[3]) && (result[3]!=a[3]).
REQ-016 SUB: computed as a + ~b + 1; result = low 4 bits; cout = bit 4 (1 = no borrow); overflow = (a[3]!=b[3]) && (result[3]!=a[3]).
REQ-017 AND, OR, XOR, NOT A: bitwise result; cout = 0; overflow = 0.
REQ-018 SHL: result = {a[2:0],1'b0}, cout = a[3]; SHR: result = {1'b0,a[3:1]}, cout = a[0]; overflow = 0 for both; b is ignored.
REQ-019 zero SHALL be derived from the result being registered in the same cycle, for every opcode.
REQ-020 Latency: one cycle; when in_valid=1 at edge N, result, flags and out_valid=1 are visible after edge N.
REQ-021 When in_valid=0 at an edge, result, cout, zero and overflow SHALL hold their previous values, and out_valid SHALL be 0.
REQ-022 Back-to-back in_valid SHALL be accepted every cycle with no stall; the block has no backpressure.

Reset
REQ-023 When rst=1 at a rising edge, result=0, cout=0, zero=0, overflow=0 and out_valid=0, regardless of in_valid.
REQ-024 rst SHALL take priority over a simultaneous in_valid; that operation is discarded.
REQ-025 The first accepted operation after rst deasserts SHALL complete with normal one-cycle latency.

Configuration
REQ-026 Macro ALU_SHIFT_EN defined: opcodes 110/111 SHALL perform SHL/SHR per REQ-018.
REQ-027 Macro ALU_SHIFT_EN undefined: opcodes 110/111 SHALL give result=0, cout=0, overflow=0, zero=1, and out_valid SHALL still assert; no shifter logic is instantiated.

Structure
REQ-028 A shared package alu_4bit_pkg SHALL hold the opcode constants (OP_ADD..OP_SHR) and the data width constant (4).
REQ-029 The add/subtract path SHALL be one sub-module, alu_4bit_addsub (inputs a, b, sub; outputs sum[3:0], cout, overflow), which alu_4bit instantiates.

Verification
REQ-030 a=1010, b=0101, op=000, in_valid=1 -> next cycle: result=1111, cout=0, zero=0, overflow=0, out_valid=1.
REQ-031 Same operands, op=001 -> result=0101, cout=1, overflow=1; op=010 -> result=0000, zero=1; op=011 and op=100 -> result=1111, zero=0.
REQ-032 a=1111, b=1111: op=000 -> result=1110, cout=1, overflow=0; op=001 -> result=0000, zero=1, cout=1, overflow=0.
REQ-033 a=0111, b=0001, op=000 -> result=1000, overflow=1, cout=0; a=1001, op=110 -> result=0010, cout=1 (ALU_SHIFT_EN defined); same stimulus without the macro -> result=0000, zero=1.
REQ-034 Issue an ADD, then hold in_valid=0 for 3 cycles -> outputs hold and out_valid=0; assert rst together with in_valid=1 -> all outputs 0 after that edge.
